fb_scanout: RTL and testbench

Framebuffer scanout reader: the read-side counterpart of the voxel engine's RAM writes. It fetches 64×60 8-bit pixels from the shared 4096×8 framebuffer RAM during horizontal blanking only, into a ping-pong pair of 64-byte line buffers. It then streams them to the video output with 4× horizontal and vertical scaling. Because it never touches the RAM while `display_on` is high, the writer owns the RAM during active display without arbitration.

---
 rtl/fb_scanout_pkg.sv | 11 +
 rtl/fb_scanout_if.sv | 9 +
 rtl/fb_scanout_line_buffer_2x64.sv | 22 ++
 rtl/fb_scanout.sv | 72 +++++++
 tb/tb_fb_scanout.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fb_scanout_pkg.sv
// fb_pkg: framebuffer geometry constants, scanout FSM states and the {row,col} RAM address pack
package fb_pkg;
  localparam int FB_COLS = 64;
  localparam int FB_ROWS = 60;
  localparam int FB_AW = 12;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fb_state_e;
  function automatic logic [FB_AW-1:0] fb_addr(input logic [5:0] row, input logic [5:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: framebuffer RAM read port (master: rd_en/rd_addr out, ram_q in one cycle after rd_en)
interface fb_scanout_if;
  import fb_pkg::*;
  logic rd_en;
  logic [FB_AW-1:0] rd_addr;
  logic [PIX_W-1:0] ram_q;
  modport master(output rd_en, rd_addr, input ram_q);
  modport slave(input rd_en, rd_addr, output ram_q);
endinterface

// File: rtl/fb_scanout_line_buffer_2x64.sv
// line_buffer_2x64: two 64x8 banks, sync write (we/wbank/waddr/wdata), registered read (rbank/raddr -> q, zeroed by rclr or reset_n)
module line_buffer_2x64
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic             wbank,
  input  logic [5:0]       waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             rbank,
  input  logic [5:0]       raddr,
  input  logic             rclr,
  output logic [PIX_W-1:0] q
);
  logic [PIX_W-1:0] mem [0:2*FB_COLS-1];
  always_ff @(posedge clk)
    if (we) mem[{wbank, waddr}] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else q <= rclr ? '0 : mem[{rbank, raddr}];
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: hblank-only framebuffer fetch into ping-pong line buffers, 4x scaled to rgb (ports: clk, reset_n, display_on, hpos, vpos, ram bus, rgb, fetch_active)
module fb_scanout
  import fb_pkg::*;
#(
  parameter logic [8:0] H_DISPLAY = 9'd256,
  parameter logic [8:0] V_DISPLAY = 9'd240,
  parameter logic [8:0] V_PRE = 9'd260
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             display_on,
  input  logic [8:0]       hpos,
  input  logic [8:0]       vpos,
  fb_scanout_if.master     ram,
  output logic [PIX_W-1:0] rgb,
  output logic             fetch_active
);
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_FETCH = 2'(FETCH);
  localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
  logic [1:0] state;
  logic [5:0] row, next_row, t_row;
  logic [4:0] cnt, cnt_d;
  logic half, bank, cap_v, pre, act, due, t_half, t_bank;
  always_comb begin
    next_row = vpos[7:2] + 6'd1;
    pre = vpos == V_PRE || vpos == V_PRE + 9'd1;
    act = vpos < V_DISPLAY && vpos[1] && next_row != 6'(FB_ROWS);
    due = hpos == H_DISPLAY && (act || pre);
    t_row = pre ? 6'd0 : next_row;
    t_half = pre ? vpos != V_PRE : vpos[0];
    t_bank = pre ? 1'b0 : ~vpos[2];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      cnt_d <= '0;
      row <= '0;
      half <= 1'b0;
      bank <= 1'b0;
      cap_v <= 1'b0;
    end else begin
      cap_v <= ram.rd_en;
      cnt_d <= cnt;
      if (state == ST_IDLE && due) begin
        state <= ST_FETCH;
        row <= t_row;
        half <= t_half;
        bank <= t_bank;
        cnt <= '0;
      end else if (state == ST_FETCH) begin
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) state <= ST_DRAIN;
      end else if (state == ST_DRAIN) state <= ST_IDLE;
    end
  assign ram.rd_en = state == ST_FETCH;
  assign ram.rd_addr = ram.rd_en ? fb_addr(row, {half, cnt}) : '0;
  assign fetch_active = state != ST_IDLE;
  line_buffer_2x64 u_lb (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (cap_v),
    .wbank  (bank),
    .waddr  ({half, cnt_d}),
    .wdata  (ram.ram_q),
    .rbank  (vpos[2]),
    .raddr  (hpos[7:2]),
    .rclr   (~display_on),
    .q      (rgb)
  );
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: frame-level reference model of fetch schedule and scaled scanout, table vectors, mid-burst reset, random RAM phases
module tb_fb_scanout;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic display_on = 1'b0;
  logic [8:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic [7:0] rgb;
  logic fetch_active;
  logic [7:0] mem [0:4095];
  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  logic [8:0] p_h = '0;
  logic [8:0] p_v = '0;
  logic p_d = 1'b0;
  typedef struct {
    logic [8:0] h;
    logic [8:0] v;
    logic d;
    logic [7:0] exp;
  } vec_t;
  vec_t tab [0:6];

  fb_scanout_if bus ();
  fb_scanout dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .display_on  (display_on),
    .hpos        (hpos),
    .vpos        (vpos),
    .ram         (bus),
    .rgb         (rgb),
    .fetch_active(fetch_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bus.ram_q <= bus.rd_en ? mem[bus.rd_addr] : bus.ram_q;

  function automatic logic [7:0] pat(input int a);
    logic [11:0] x;
    x = 12'(a);
    return x[7:0] ^ x[11:4];
  endfunction

  function automatic bit fetch_due(input int v);
    return (v < 240 && v % 4 >= 2 && v / 4 + 1 != 60) || v == 260 || v == 261;
  endfunction

  function automatic int fetch_base(input int v);
    int row, half;
    row = v < 240 ? v / 4 + 1 : 0;
    half = v < 240 ? int'(v % 4 == 3) : int'(v == 261);
    return row * 64 + half * 32;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h (hpos=%0d vpos=%0d t=%0t)", name, act, exp, hpos, vpos, $time);
    end
  endtask

  task automatic step(input logic [8:0] h, input logic [8:0] v, input logic d, input bit chk_rgb, input bit nofetch);
    bit due, exp_rd, exp_fa;
    @(negedge clk);
    hpos = h;
    vpos = v;
    display_on = d;
    #1;
    due = fetch_due(int'(v)) && !nofetch;
    exp_rd = due && h >= 257 && h <= 288;
    exp_fa = due && h >= 257 && h <= 289;
    if (bus.rd_en) rd_cnt++;
    chk("rd_en", int'(bus.rd_en), int'(exp_rd));
    chk("fetch_active", int'(fetch_active), int'(exp_fa));
    if (exp_rd) chk("rd_addr", int'(bus.rd_addr), fetch_base(int'(v)) + int'(h) - 257);
    chk("rd_en_in_display", int'(bus.rd_en && d), 0);
    chk("bank_hazard", int'(dut.cap_v && d && dut.bank == v[2]), 0);
    if (chk_rgb) chk("rgb", int'(rgb), p_d ? int'(mem[{p_v[7:2], p_h[7:2]}]) : 0);
    p_h = h;
    p_v = v;
    p_d = d;
  endtask

  task automatic run_line(input int v, input int h0, input int h1, input bit chk_rgb, input bit nofetch, input bit rnd);
    logic d;
    for (int h = h0; h <= h1; h++) begin
      d = v < 240 && h < 256;
      if (rnd && $urandom_range(0, 15) == 0) d = 1'b0;
      step(9'(h), 9'(v), d, chk_rgb, nofetch);
    end
  endtask

  function automatic int h_start(input int v);
    return v < 240 ? 0 : 250;
  endfunction

  function automatic int h_end(input int v);
    return (v >= 240 || v % 4 >= 2) ? 308 : 260;
  endfunction

  task automatic set_vec(input int i, input int h, input int v, input bit d, input logic [7:0] e);
    tab[i].h = 9'(h);
    tab[i].v = 9'(v);
    tab[i].d = d;
    tab[i].exp = e;
  endtask

  initial begin
    int r;
    for (int a = 0; a < 4096; a++) mem[a] = pat(a);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rd_en", int'(bus.rd_en), 0);
    chk("reset_rd_addr", int'(bus.rd_addr), 0);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_fetch_active", int'(fetch_active), 0);
    reset_n = 1'b1;

    run_line(260, 250, 308, 0, 0, 0);
    run_line(261, 250, 308, 0, 0, 0);
    for (int v = 0; v < 260; v++) begin
      rd_cnt = 0;
      run_line(v, h_start(v), h_end(v), 1, 0, 0);
      if (v == 0 || v == 1 || v == 238 || v == 250) chk("no_fetch_line_count", rd_cnt, 0);
      if (v == 2 || v == 3) chk("burst_len", rd_cnt, 32);
    end

    set_vec(0, 0, 0, 1'b1, pat(58 * 64 + 0));
    set_vec(1, 20, 4, 1'b1, pat(59 * 64 + 5));
    set_vec(2, 252, 236, 1'b1, pat(59 * 64 + 63));
    set_vec(3, 100, 8, 1'b0, 8'h00);
    set_vec(4, 255, 3, 1'b1, pat(58 * 64 + 63));
    set_vec(5, 130, 201, 1'b0, 8'h00);
    set_vec(6, 130, 201, 1'b1, pat(58 * 64 + 32));
    for (int i = 0; i < 7; i++) begin
      step(tab[i].h, tab[i].v, tab[i].d, 0, 0);
      @(negedge clk);
      #1;
      chk($sformatf("table_rgb[%0d]", i), int'(rgb), int'(tab[i].exp));
    end

    run_line(7, 0, 266, 0, 0, 0);
    chk("tenth_rd_addr", int'(bus.rd_addr), 2 * 64 + 32 + 9);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_rd_en", int'(bus.rd_en), 0);
    chk("async_rst_fetch_active", int'(fetch_active), 0);
    chk("async_rst_rgb", int'(rgb), 0);
    run_line(7, 267, 270, 0, 1, 0);
    reset_n = 1'b1;
    run_line(7, 271, 308, 0, 1, 0);
    for (int v = 8; v < 16; v++) begin
      rd_cnt = 0;
      run_line(v, 0, h_end(v), v >= 12, 0, 0);
      if (v == 10) chk("post_reset_burst_len", rd_cnt, 32);
    end

    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    run_line(260, 250, 308, 0, 0, 1);
    run_line(261, 250, 308, 0, 0, 1);
    for (int v = 0; v < 4; v++) run_line(v, 0, h_end(v), 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      r = int'($urandom_range(1, 59));
      for (int v = 4 * r - 2; v < 4 * r + 4; v++) run_line(v, 0, h_end(v), v >= 4 * r, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
